// File: rtl/auction_pkg.sv
// Shared definitions for the sealed-bid auction: FSM encoding, slot count and
// the slot packing macro used by the collector, the comparator and their benches.
`ifndef AUCTION_SLOT
`define AUCTION_SLOT(vec, i, w) vec[(i)*(w) +: (w)]
`endif

package auction_pkg;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } auction_state_e;

  function automatic int nb_of(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/auction_timer.sv
// Round timeout counter, built only with AUCTION_TIMEOUT_EN. Starts on the first
// accepted bid, holds expire high once TIMEOUT is reached until cleared.
`ifdef AUCTION_TIMEOUT_EN
module auction_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic          run_q;
  logic [CW-1:0] cnt_q;

  // Counting stops at the limit, so the collector sees a level it can act on once.
  assign expire = run_q && (cnt_q == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (clear) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= CW'(1);
    end else if (run_q && !expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/auction_bid_collector.sv
// Collects one bid per bidder slot and presents the packed vector downstream.
// Optional round timeout is enabled by defining AUCTION_TIMEOUT_EN.
module auction_bid_collector
  import auction_pkg::*;
#(
  parameter int N       = 3,
  parameter int W       = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_id,
  input  logic [W-1:0]           in_bid,
  output logic                   dup_err,
  output logic [nb_of(N)*W-1:0]  bid,
  output logic                   bid_valid,
  input  logic                   bid_ready,
  output logic [nb_of(N)-1:0]    rcv_mask,
  output logic                   timed_out
);

  localparam int NB = nb_of(N);
  localparam logic [N:0] LAST_CNT = (N+1)'(NB - 1);

  // Handshakes: a bid moves when in_valid && in_ready at a rising edge; the
  // vector moves when bid_valid && bid_ready. Valid never waits on ready.
  auction_state_e    state_q;
  logic [NB*W-1:0]   slots_q;
  logic [NB-1:0]     rcv_mask_q;
  logic [N:0]        count_q;
  logic              dup_err_q;
  logic              timed_out_q;

  logic accept, new_bid, last_bid, handshake, timer_expire;

  assign in_ready  = (state_q == ST_COLLECT) && !rst;
  assign accept    = in_valid && in_ready;
  assign new_bid   = accept && !rcv_mask_q[in_id];
  assign last_bid  = new_bid && (count_q == LAST_CNT);
  assign handshake = (state_q == ST_PRESENT) && bid_ready;

`ifdef AUCTION_TIMEOUT_EN
  auction_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (new_bid && (count_q == '0)),
    .clear  (handshake),
    .expire (timer_expire)
  );
`else
  // Without the timer a round only closes when every slot is filled.
  assign timer_expire = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      slots_q     <= '0;
      rcv_mask_q  <= '0;
      count_q     <= '0;
      dup_err_q   <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      dup_err_q <= accept && rcv_mask_q[in_id];
      case (state_q)
        ST_COLLECT: begin
          if (new_bid) begin
            `AUCTION_SLOT(slots_q, in_id, W) <= in_bid;
            rcv_mask_q[in_id] <= 1'b1;
            count_q           <= count_q + 1'b1;
          end
          // A full round beats a coincident timeout.
          if (last_bid) begin
            state_q <= ST_PRESENT;
          end else if (timer_expire) begin
            state_q     <= ST_PRESENT;
            timed_out_q <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (bid_ready) begin
            slots_q     <= '0;
            rcv_mask_q  <= '0;
            count_q     <= '0;
            timed_out_q <= 1'b0;
            state_q     <= ST_COLLECT;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign bid       = slots_q;
  assign rcv_mask  = rcv_mask_q;
  assign bid_valid = (state_q == ST_PRESENT);
  assign dup_err   = dup_err_q;
  assign timed_out = timed_out_q;

endmodule

// File: tb/tb_auction_bid_collector.sv
// Scoreboard bench for auction_bid_collector (N=3, W=3): directed rounds push
// the expected {timed_out, rcv_mask, bid} and a monitor checks each handshake.
module tb_auction_bid_collector;

  localparam int N  = 3;
  localparam int W  = 3;
  localparam int NB = 8;
  localparam int EW = 1 + NB + NB*W;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_id;
  logic [W-1:0]  in_bid;
  logic          dup_err;
  logic [NB*W-1:0] bid;
  logic          bid_valid;
  logic          bid_ready;
  logic [NB-1:0] rcv_mask;
  logic          timed_out;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;

  auction_bid_collector #(.N(N), .W(W), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_id     (in_id),
    .in_bid    (in_bid),
    .dup_err   (dup_err),
    .bid       (bid),
    .bid_valid (bid_valid),
    .bid_ready (bid_ready),
    .rcv_mask  (rcv_mask),
    .timed_out (timed_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_bid(input int id, input int val);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_id    = N'(id);
    in_bid   = W'(val);
    for (int c = 0; c < 20 && !done; c++) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic push_exp(input logic to, input logic [NB-1:0] m, input logic [NB*W-1:0] v);
    exp_q.push_back({to, m, v});
  endtask

  task automatic do_handshake();
    bid_ready = 1'b1;
    @(negedge clk);
    bid_ready = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (bid_valid) valid_cycles++;
      if (bid_valid && bid_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_vector", 64'(bid), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("vec_bid",       64'(bid),       64'(e[NB*W-1:0]));
          check("vec_rcv_mask",  64'(rcv_mask),  64'(e[NB*W +: NB]));
          check("vec_timed_out", 64'(timed_out), 64'(e[EW-1]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [NB*W-1:0] V1 = {3'd2,3'd5,3'd7,3'd3,3'd4,3'd1,3'd0,3'd6};
  localparam logic [NB*W-1:0] V3 = {3'd7,3'd6,3'd5,3'd4,3'd4,3'd2,3'd1,3'd0};
  localparam logic [NB*W-1:0] V4 = {3'd0,3'd1,3'd2,3'd3,3'd4,3'd5,3'd6,3'd7};
  localparam logic [NB*W-1:0] V6A = {3'd5,3'd2,3'd7,3'd4,3'd1,3'd6,3'd3,3'd0};
  localparam logic [NB*W-1:0] V6B = {3'd2,3'd3,3'd0,3'd1,3'd6,3'd7,3'd4,3'd5};

  initial begin
    int vals1 [8];
    int vc0;
    vals1 = '{6, 0, 1, 4, 3, 7, 5, 2};
    rst = 1'b1; in_valid = 1'b0; in_id = '0; in_bid = '0; bid_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bid_valid", 64'(bid_valid), 64'd0);
    check("rst_dup_err",   64'(dup_err),   64'd0);
    check("rst_timed_out", 64'(timed_out), 64'd0);
    check("rst_rcv_mask",  64'(rcv_mask),  64'd0);
    check("rst_bid",       64'(bid),       64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready),  64'd1);

    // 1: in-order round, one-cycle presentation latency
    push_exp(1'b0, 8'hFF, V1);
    for (int i = 0; i < 7; i++) send_bid(i, vals1[i]);
    check("t1_not_yet_valid", 64'(bid_valid), 64'd0);
    send_bid(7, vals1[7]);
    check("t1_bid_valid", 64'(bid_valid), 64'd1);
    check("t1_in_ready",  64'(in_ready),  64'd0);
    check("t1_mask",      64'(rcv_mask),  64'hFF);
    do_handshake();

    // 2: reverse order, backpressure for 5 cycles
    push_exp(1'b0, 8'hFF, V1);
    for (int i = 7; i >= 0; i--) send_bid(i, vals1[i]);
    for (int c = 0; c < 5; c++) begin
      check("t2_hold_valid", 64'(bid_valid), 64'd1);
      check("t2_hold_ready", 64'(in_ready),  64'd0);
      check("t2_hold_bid",   64'(bid),       64'(V1));
      @(negedge clk);
    end
    do_handshake();
    check("t2_after_valid", 64'(bid_valid), 64'd0);
    check("t2_after_ready", 64'(in_ready),  64'd1);
    check("t2_after_mask",  64'(rcv_mask),  64'd0);
    check("t2_after_bid",   64'(bid),       64'd0);

    // 3: duplicate for slot 3 is dropped with a one-cycle pulse
    send_bid(3, 4);
    check("t3_no_dup", 64'(dup_err), 64'd0);
    send_bid(3, 7);
    check("t3_dup_pulse", 64'(dup_err),  64'd1);
    check("t3_slot3",     64'(bid[11:9]), 64'd4);
    check("t3_mask",      64'(rcv_mask), 64'h08);
    @(negedge clk);
    check("t3_dup_clear", 64'(dup_err),  64'd0);
    push_exp(1'b0, 8'hFF, V3);
    for (int i = 0; i < 8; i++) if (i != 3) send_bid(i, i);
    check("t3_full_valid", 64'(bid_valid), 64'd1);
    do_handshake();

    // 4: reset mid-round discards partial bids
    for (int i = 0; i < 5; i++) send_bid(i, i + 1);
    check("t4_partial_mask", 64'(rcv_mask), 64'h1F);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_mask",  64'(rcv_mask),  64'd0);
    check("t4_rst_bid",   64'(bid),       64'd0);
    check("t4_rst_valid", 64'(bid_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t4_rst_ready", 64'(in_ready), 64'd1);
    push_exp(1'b0, 8'hFF, V4);
    for (int i = 0; i < 8; i++) send_bid(i, 7 - i);
    do_handshake();

`ifdef AUCTION_TIMEOUT_EN
    // 5: partial round forced closed by the timer
    begin
      bit seen;
      seen = 1'b0;
      push_exp(1'b1, 8'h05, {15'd0, 3'd3, 3'd0, 3'd5});
      send_bid(0, 5);
      send_bid(2, 3);
      for (int c = 0; c < 40 && !seen; c++) begin
        if (bid_valid) seen = 1'b1;
        else @(negedge clk);
      end
      check("t5_timeout_seen", 64'(seen), 64'd1);
      check("t5_timed_out",    64'(timed_out), 64'd1);
      do_handshake();
      check("t5_timed_out_clr", 64'(timed_out), 64'd0);
    end
`else
    check("t5_timed_out_tied", 64'(timed_out), 64'd0);
`endif

    // 6: back-to-back rounds with bid_ready held high
    vc0 = valid_cycles;
    bid_ready = 1'b1;
    push_exp(1'b0, 8'hFF, V6A);
    push_exp(1'b0, 8'hFF, V6B);
    for (int i = 0; i < 8; i++) send_bid(i, (i * 3) % 8);
    for (int i = 0; i < 8; i++) send_bid(i, i ^ 5);
    repeat (3) @(negedge clk);
    bid_ready = 1'b0;
    check("t6_valid_cycles", 64'(valid_cycles - vc0), 64'd2);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
